// File: rtl/device_event_serializer.sv
// rtl/device_event_serializer.sv - serializes per-device on/off transitions into one event per cycle
//
// Purpose:
//   Samples an 8-bit device status vector and detects each device's on/off
//   transition. Transitions are queued per device and emitted one per cycle,
//   with round-robin arbitration. The event stream drives a downstream
//   active-device counter.
//   An opposite transition on a device whose event is still waiting cancels
//   that event, so the net on/off count seen downstream always tracks the
//   true number of active devices.
//
// Ports:
//   clk          in   single clock; all state updates on the rising edge
//   rst          in   synchronous active-high reset
//   dev_status   in   [7:0] level status of devices 0..7 (1 = on)
//   hold         in   downstream stall; 1 = emit no event this cycle
//   change       out  registered one-cycle pulse per emitted event
//   on_off       out  registered event direction (1 = on), 0 when change=0
//   dev_id       out  [2:0] registered device index, 0 when change=0
//   pending_cnt  out  [3:0] number of devices with an un-emitted event

module device_event_serializer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dev_status,
    input  logic       hold,
    output logic       change,
    output logic       on_off,
    output logic [2:0] dev_id,
    output logic [3:0] pending_cnt
);

    // Sampling pipeline: cur is the current registered status, last is the
    // previous one. Both clear on reset, so devices already on when reset
    // releases appear as rising edges.
    logic [7:0] cur_q,  cur_d;
    logic [7:0] last_q, last_d;

    // Per-device event state: pend marks a waiting event, dir its direction.
    logic [7:0] pend_q, pend_d;
    logic [7:0] dir_q,  dir_d;

    // Round-robin search start.
    logic [2:0] rr_ptr_q, rr_ptr_d;

    // Registered event outputs.
    logic       change_q, change_d;
    logic       on_off_q, on_off_d;
    logic [2:0] dev_id_q, dev_id_d;

    // Transition detect.
    logic [7:0] edge_vec;

    // Arbitration results.
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic [7:0] grant_vec;
    logic [2:0] search_idx;

    assign edge_vec = cur_q ^ last_q;

    // Round-robin arbiter: scan upward from rr_ptr with 3-bit wraparound;
    // the first waiting device wins. No grant while stalled.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 3'd0;
        search_idx  = 3'd0;
        for (int k = 0; k < 8; k++) begin
            search_idx = rr_ptr_q + 3'(k);
            if (!hold && !grant_valid && pend_q[search_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = search_idx;
            end
        end
    end

    assign grant_vec = grant_valid ? (8'b0000_0001 << grant_idx) : 8'b0000_0000;

    // Per-device pending update.
    // A new edge normally queues an event. If an event is already waiting and
    // is not being emitted this cycle, the new edge is its opposite and the
    // two cancel. If the waiting event is being emitted this cycle, the new
    // edge becomes a fresh event, so the device is never lost.
    always_comb begin
        pend_d = pend_q;
        dir_d  = dir_q;
        for (int i = 0; i < 8; i++) begin
            if (edge_vec[i]) begin
                if (!pend_q[i] || grant_vec[i]) begin
                    pend_d[i] = 1'b1;
                    dir_d[i]  = cur_q[i];
                end else begin
                    pend_d[i] = 1'b0;
                end
            end else if (grant_vec[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    // Output and pointer next-state.
    always_comb begin
        cur_d    = dev_status;
        last_d   = cur_q;
        rr_ptr_d = rr_ptr_q;
        change_d = 1'b0;
        on_off_d = 1'b0;
        dev_id_d = 3'd0;
        if (grant_valid) begin
            change_d = 1'b1;
            on_off_d = dir_q[grant_idx];
            dev_id_d = grant_idx;
            rr_ptr_d = grant_idx + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q    <= 8'd0;
            last_q   <= 8'd0;
            pend_q   <= 8'd0;
            dir_q    <= 8'd0;
            rr_ptr_q <= 3'd0;
            change_q <= 1'b0;
            on_off_q <= 1'b0;
            dev_id_q <= 3'd0;
        end else begin
            cur_q    <= cur_d;
            last_q   <= last_d;
            pend_q   <= pend_d;
            dir_q    <= dir_d;
            rr_ptr_q <= rr_ptr_d;
            change_q <= change_d;
            on_off_q <= on_off_d;
            dev_id_q <= dev_id_d;
        end
    end

    // Popcount of the waiting events; at most 8, so 4 bits never wrap.
    always_comb begin
        pending_cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            pending_cnt = pending_cnt + {3'd0, pend_q[i]};
        end
    end

    assign change = change_q;
    assign on_off = on_off_q;
    assign dev_id = dev_id_q;

endmodule

// File: tb/tb_device_event_serializer.sv
// tb/tb_device_event_serializer.sv - self-checking bench for device_event_serializer

module tb_device_event_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] dev_status;
    logic       hold;
    logic       change;
    logic       on_off;
    logic [2:0] dev_id;
    logic [3:0] pending_cnt;

    int errors = 0;
    int checks = 0;

    device_event_serializer dut (
        .clk         (clk),
        .rst         (rst),
        .dev_status  (dev_status),
        .hold        (hold),
        .change      (change),
        .on_off      (on_off),
        .dev_id      (dev_id),
        .pending_cnt (pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: device view in plain integer arrays.
    int m_cur  [8];
    int m_last [8];
    int m_pend [8];
    int m_dir  [8];
    int m_rr;
    int e_ch, e_oo, e_id, e_cnt;
    int net_sum;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_cur[i] = 0; m_last[i] = 0; m_pend[i] = 0; m_dir[i] = 0;
        end
        m_rr = 0; e_ch = 0; e_oo = 0; e_id = 0; e_cnt = 0;
    endtask

    task automatic model_step(input logic [7:0] st, input logic hd, input logic rs);
        int g;
        if (rs) begin
            model_reset();
            return;
        end
        g = -1;
        if (!hd) begin
            for (int k = 0; k < 8; k++) begin
                if (g < 0 && m_pend[(m_rr + k) % 8] != 0) g = (m_rr + k) % 8;
            end
        end
        e_ch = (g >= 0) ? 1 : 0;
        e_oo = (g >= 0) ? m_dir[g] : 0;
        e_id = (g >= 0) ? g : 0;
        if (g >= 0) m_rr = (g + 1) % 8;
        for (int i = 0; i < 8; i++) begin
            if (m_cur[i] != m_last[i]) begin
                if (m_pend[i] == 0 || i == g) begin
                    m_pend[i] = 1;
                    m_dir[i]  = m_cur[i];
                end else begin
                    m_pend[i] = 0;
                end
            end else if (i == g) begin
                m_pend[i] = 0;
            end
            m_last[i] = m_cur[i];
            m_cur[i]  = st[i] ? 1 : 0;
        end
        e_cnt = 0;
        for (int i = 0; i < 8; i++) e_cnt += m_pend[i];
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, then
    // sample the DUT 1 time unit after the edge and compare with the model.
    task automatic step(input logic [7:0] st, input logic hd, input logic rs);
        dev_status = st;
        hold       = hd;
        rst        = rs;
        @(posedge clk);
        model_step(st, hd, rs);
        #1;
        check("model_change", int'(change), e_ch);
        check("model_on_off", int'(on_off), e_oo);
        check("model_dev_id", int'(dev_id), e_id);
        check("model_pending_cnt", int'(pending_cnt), e_cnt);
        if (rs) net_sum = 0;
        else if (change) net_sum += on_off ? 1 : -1;
    endtask

    typedef struct {
        logic [7:0] st;
        logic       hd;
        logic       rs;
        logic       ch;
        logic       oo;
        logic [2:0] id;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic [7:0] st, input logic hd, input logic rs,
                                input logic ch, input logic oo, input logic [2:0] id,
                                input logic [3:0] cnt);
        vec_t v;
        v.st = st; v.hd = hd; v.rs = rs; v.ch = ch; v.oo = oo; v.id = id; v.cnt = cnt;
        return v;
    endfunction

    int ids[$];
    int peak;
    int all_on;
    int pulses;
    int emitted;
    logic [7:0] rnd_st;

    initial begin
        model_reset();
        net_sum    = 0;
        dev_status = 8'h00;
        hold       = 1'b0;
        rst        = 1'b1;

        // 8'h05 held through reset: two on events, dev 0 then dev 2;
        // then device 3 on, then device 3 off with a single off pulse at E+2.
        tbl[0]  = mk(8'h05, 0, 1, 0, 0, 3'd0, 4'd0);
        tbl[1]  = mk(8'h05, 0, 1, 0, 0, 3'd0, 4'd0);
        tbl[2]  = mk(8'h05, 0, 0, 0, 0, 3'd0, 4'd0);
        tbl[3]  = mk(8'h05, 0, 0, 0, 0, 3'd0, 4'd2);
        tbl[4]  = mk(8'h05, 0, 0, 1, 1, 3'd0, 4'd1);
        tbl[5]  = mk(8'h05, 0, 0, 1, 1, 3'd2, 4'd0);
        tbl[6]  = mk(8'h05, 0, 0, 0, 0, 3'd0, 4'd0);
        tbl[7]  = mk(8'h0D, 0, 0, 0, 0, 3'd0, 4'd0);
        tbl[8]  = mk(8'h0D, 0, 0, 0, 0, 3'd0, 4'd1);
        tbl[9]  = mk(8'h0D, 0, 0, 1, 1, 3'd3, 4'd0);
        tbl[10] = mk(8'h0D, 0, 0, 0, 0, 3'd0, 4'd0);
        tbl[11] = mk(8'h05, 0, 0, 0, 0, 3'd0, 4'd0);
        tbl[12] = mk(8'h05, 0, 0, 0, 0, 3'd0, 4'd1);
        tbl[13] = mk(8'h05, 0, 0, 1, 0, 3'd3, 4'd0);
        tbl[14] = mk(8'h05, 0, 0, 0, 0, 3'd0, 4'd0);
        tbl[15] = mk(8'h05, 0, 0, 0, 0, 3'd0, 4'd0);

        for (int v = 0; v < 16; v++) begin
            step(tbl[v].st, tbl[v].hd, tbl[v].rs);
            if ({change, on_off, dev_id, pending_cnt} !=
                {tbl[v].ch, tbl[v].oo, tbl[v].id, tbl[v].cnt}) begin
                errors++;
                $display("FAIL vec%0d: got ch=%0d oo=%0d id=%0d cnt=%0d, expected ch=%0d oo=%0d id=%0d cnt=%0d",
                         v, change, on_off, dev_id, pending_cnt,
                         tbl[v].ch, tbl[v].oo, tbl[v].id, tbl[v].cnt);
            end
            checks++;
        end

        // All eight on in one cycle with rr_ptr=5: grant dev 4 twice to park rr at 5.
        step(8'h00, 0, 1);
        for (int c = 0; c < 5; c++) step(8'h10, 0, 0);
        for (int c = 0; c < 5; c++) step(8'h00, 0, 0);
        ids.delete();
        peak = 0; all_on = 1;
        for (int c = 0; c < 14; c++) begin
            step(8'hFF, 0, 0);
            if (change) begin
                ids.push_back(int'(dev_id));
                if (!on_off) all_on = 0;
            end
            if (int'(pending_cnt) > peak) peak = int'(pending_cnt);
        end
        check("burst_pulses", ids.size(), 8);
        for (int k = 0; k < 8; k++) begin
            check("burst_order", (k < ids.size()) ? ids[k] : -1, (5 + k) % 8);
        end
        check("burst_all_on", all_on, 1);
        check("burst_peak", peak, 8);
        check("burst_drained", int'(pending_cnt), 0);

        // Drain to all-off, then a 1-cycle bit-5 glitch under hold cancels.
        for (int c = 0; c < 12; c++) step(8'h00, 0, 0);
        peak = 0;
        step(8'h20, 1, 0);
        for (int c = 0; c < 4; c++) begin
            step(8'h00, 1, 0);
            if (int'(pending_cnt) > peak) peak = int'(pending_cnt);
        end
        check("glitch_pend_seen", peak, 1);
        check("glitch_pend_cleared", int'(pending_cnt), 0);
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            step(8'h00, 0, 0);
            if (change) pulses++;
        end
        check("glitch_no_pulse", pulses, 0);

        // Three events stalled by hold for 10 cycles, then released.
        step(8'h07, 1, 0);
        step(8'h07, 1, 0);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            step(8'h07, 1, 0);
            if (change) pulses++;
        end
        check("hold_no_pulse", pulses, 0);
        check("hold_pending", int'(pending_cnt), 3);
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            step(8'h07, 0, 0);
            if (change && on_off) pulses++;
        end
        check("hold_release_pulses", pulses, 3);
        check("hold_release_drained", int'(pending_cnt), 0);

        // Reset in the middle of an 8-event burst after 3 emitted.
        step(8'h00, 0, 1);
        emitted = 0;
        for (int c = 0; c < 20 && emitted < 3; c++) begin
            step(8'hFF, 0, 0);
            if (change) emitted++;
        end
        check("midburst_emitted", emitted, 3);
        step(8'hFF, 0, 1);
        check("midburst_change", int'(change), 0);
        check("midburst_pending", int'(pending_cnt), 0);
        pulses = 0;
        for (int c = 0; c < 14; c++) begin
            step(8'hFF, 0, 0);
            if (change && on_off) pulses++;
        end
        check("midburst_fresh_events", pulses, 8);

        // Randomized traffic against the model, then a net-count check.
        rnd_st = 8'hFF;
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(0, 5))
                0:       rnd_st = 8'($urandom);
                1, 2:    rnd_st = rnd_st ^ (8'h01 << $urandom_range(0, 7));
                default: rnd_st = rnd_st;
            endcase
            step(rnd_st, ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end
        for (int c = 0; c < 20; c++) step(rnd_st, 0, 0);
        check("net_count", net_sum, $countones(rnd_st));
        check("final_drained", int'(pending_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
